lr_step_scheduler: RTL and testbench
====================================

Name: lr_step_scheduler

Overview:
- Sequential index generator directly upstream of the current-learning-rate lookup.
- Counts completed weight-update iterations during one training run and drives the learning-rate index consumed by that lookup.
- Index advances once every ITER_PER_STEP iterations. Each step halves the learning rate downstream.
- The run ends after ITER_PER_STEP iterations at the final index.

Parameters:
LR_SIZE, 7, number of learning-rate entries; legal indices 0..LR_SIZE-1; must be >= 2
ITER_PER_STEP, 4, completed iterations per index step; must be >= 1
IDX_W, $clog2(LR_SIZE), width of LR_index (derived, not overridden)
CNT_W, max(1,$clog2(ITER_PER_STEP)), width of internal iteration counter (derived)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin (or restart) a training run
iter_done  input  1  one-cycle pulse per completed weight update
LR_index  output  IDX_W  registered learning-rate index to the lookup stage
busy  output  1  high while a run is in progress
lr_step  output  1  one-cycle pulse in the cycle LR_index takes a new nonzero value
sched_done  output  1  one-cycle pulse when the run completes

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-run):
  - LR_index=0, busy=0, lr_step=0, sched_done=0, iter counter=0, state=IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states:
  - IDLE: LR_index=0, busy=0. iter_done is ignored. start -> RUN next cycle, with busy=1, LR_index=0, counter=0.
  - RUN (LR_index < LR_SIZE-1):
    - Each sampled iter_done increments the counter.
    - On the iter_done that brings the count to ITER_PER_STEP, the counter clears and LR_index increments next cycle, with lr_step=1 for that cycle.
    - If the new index is LR_SIZE-1, the FSM goes to LAST.
  - LAST (LR_index = LR_SIZE-1): counting is identical to RUN. On the ITER_PER_STEP-th iter_done, the next cycle has:
    - sched_done=1 for one cycle
    - busy=0
    - LR_index=0
    - counter=0
    - state=IDLE
- Latency: output change appears the cycle after the qualifying iter_done edge.
- Priority: start in RUN or LAST restarts the run (LR_index=0, counter=0, state=RUN, busy=1) and discards any iter_done in the same cycle. No lr_step or sched_done pulse is produced by a restart.
- start and iter_done together in IDLE: the run starts and iter_done is not counted.
- LR_index never exceeds LR_SIZE-1, so the downstream default-to-zero branch is never exercised during a run.
- ITER_PER_STEP=1: every iter_done steps the index. The counter stays 0.
- Pulses: lr_step and sched_done are never high in the same cycle and are never high for more than one cycle. busy is low in the sched_done cycle.
- Full run length: exactly LR_SIZE*ITER_PER_STEP counted iter_done pulses.
- iter_done held high continuously counts once per cycle. It is legal and must be handled.

Test Plan:
- Reset mid-run: with defaults, start, 9 iter_done (LR_index=2), assert rst_n low between edges -> LR_index=0 and busy=0 immediately, asynchronously; no pulses after release.
- Nominal run, defaults: start, then 28 iter_done pulses spaced 3 cycles apart -> LR_index steps 0..6 after pulses 4,8,...,24, with lr_step asserted exactly 6 times; sched_done one cycle after pulse 28, then LR_index=0 and busy=0.
- Back-to-back: start, then iter_done held high 28 consecutive cycles -> LR_index increments every 4th cycle; sched_done in cycle 29 after the first pulse; iter_done cycles after that are ignored in IDLE.
- Restart: start, 10 iter_done (LR_index=2, count=2), then start together with iter_done -> next cycle LR_index=0, busy=1, no lr_step; 4 further iter_done -> LR_index=1.
- Idle immunity: 5 iter_done with no start -> LR_index=0, busy=0, no pulses; start and iter_done in the same cycle -> the iteration is not counted, and the first step occurs after 4 more pulses.
- Parameter corners: LR_SIZE=2, ITER_PER_STEP=1 -> start, iter_done gives LR_index=1 with lr_step; a second iter_done gives sched_done and LR_index=0.

Source files
------------

// File: rtl/lr_step_scheduler.sv
// Learning-rate index scheduler: counts completed weight updates during a run and
// advances the registered LR index once every ITER_PER_STEP iterations.
module lr_step_scheduler #(
  parameter  int LR_SIZE       = 7,
  parameter  int ITER_PER_STEP = 4,
  localparam int IDX_W         = (LR_SIZE > 1) ? $clog2(LR_SIZE) : 1,
  localparam int CNT_W         = (ITER_PER_STEP > 1) ? $clog2(ITER_PER_STEP) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             iter_done,
  output logic [IDX_W-1:0] LR_index,
  output logic             busy,
  output logic             lr_step,
  output logic             sched_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ITER_PER_STEP - 1);
  localparam logic [IDX_W-1:0] IDX_PRELAST = IDX_W'(LR_SIZE - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               lr_step_q, lr_step_d;
  logic               sched_done_q, sched_done_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    lr_step_d    = 1'b0;
    sched_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      RUN, LAST: begin
        // A restart wins over a same-cycle iteration and produces no pulse.
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (iter_done) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (state_q == RUN) begin
              idx_d     = idx_q + 1'b1;
              lr_step_d = 1'b1;
              if (idx_q == IDX_PRELAST) state_d = LAST;
            end else begin
              idx_d        = '0;
              busy_d       = 1'b0;
              sched_done_d = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      lr_step_q    <= 1'b0;
      sched_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      lr_step_q    <= lr_step_d;
      sched_done_q <= sched_done_d;
    end
  end

  assign LR_index   = idx_q;
  assign busy       = busy_q;
  assign lr_step    = lr_step_q;
  assign sched_done = sched_done_q;

endmodule

// File: tb/tb_lr_step_scheduler.sv
// Self-checking bench for lr_step_scheduler: vector table, hand-written run sequences,
// and randomized stimulus against an iteration-count reference model.
module tb_lr_step_scheduler;

  localparam int LR  = 7;
  localparam int IPS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, iter_done;
  logic [2:0] LR_index;
  logic       busy, lr_step, sched_done;

  logic       start_c, iter_c;
  logic [0:0] idx_c;
  logic       busy_c, step_c, done_c;

  lr_step_scheduler #(.LR_SIZE(LR), .ITER_PER_STEP(IPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iter_done(iter_done),
    .LR_index(LR_index), .busy(busy), .lr_step(lr_step), .sched_done(sched_done)
  );

  lr_step_scheduler #(.LR_SIZE(2), .ITER_PER_STEP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .iter_done(iter_c),
    .LR_index(idx_c), .busy(busy_c), .lr_step(step_c), .sched_done(done_c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a run is just a count of accepted iterations; index is count / IPS.
  bit   m_run;
  int   m_n;
  logic m_step, m_done;

  task automatic model_reset();
    m_run = 0; m_n = 0; m_step = 0; m_done = 0;
  endtask

  task automatic model_step(input logic s, input logic i);
    m_step = 0; m_done = 0;
    if (s) begin
      m_run = 1; m_n = 0;
    end else if (m_run && i) begin
      m_n++;
      if (m_n == LR * IPS) begin
        m_done = 1; m_run = 0; m_n = 0;
      end else if (m_n % IPS == 0) begin
        m_step = 1;
      end
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [2:0] idx;
    idx = m_run ? 3'(m_n / IPS) : 3'd0;
    return {idx, logic'(m_run), m_step, m_done};
  endfunction

  function automatic logic [5:0] dut_out();
    return {LR_index, busy, lr_step, sched_done};
  endfunction

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic s, input logic i);
    @(negedge clk);
    start = s; iter_done = i;
    model_step(s, i);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string name, input logic s, input logic i);
    cyc(s, i);
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  typedef struct {
    logic       s;
    logic       i;
    logic [2:0] idx;
    logic       busy;
    logic       step;
    logic       done;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic s, logic i, logic [2:0] idx, logic b, logic st, logic d);
    vec_t v;
    v.s = s; v.i = i; v.idx = idx; v.busy = b; v.step = st; v.done = d;
    return v;
  endfunction

  int steps, dones, done_at;

  initial begin
    rst_n = 1'b0; start = 0; iter_done = 0; start_c = 0; iter_c = 0;
    model_reset();

    // Table: idle immunity, start+iter not counted, first step, restart with iter, step after restart.
    vecs[0]  = mk(0, 1, 3'd0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 3'd0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 3'd0, 1, 0, 0);
    vecs[3]  = mk(0, 1, 3'd0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 3'd0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 3'd0, 1, 0, 0);
    vecs[6]  = mk(0, 1, 3'd0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 3'd1, 1, 1, 0);
    vecs[8]  = mk(0, 0, 3'd1, 1, 0, 0);
    vecs[9]  = mk(0, 1, 3'd1, 1, 0, 0);
    vecs[10] = mk(1, 1, 3'd0, 1, 0, 0);
    vecs[11] = mk(0, 1, 3'd0, 1, 0, 0);
    vecs[12] = mk(0, 1, 3'd0, 1, 0, 0);
    vecs[13] = mk(0, 1, 3'd0, 1, 0, 0);
    vecs[14] = mk(0, 1, 3'd1, 1, 1, 0);
    vecs[15] = mk(0, 0, 3'd1, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_out()), 32'(6'b000_0_0_0));
    check("reset_state_corner", 32'({idx_c, busy_c, step_c, done_c}), 32'(4'b0_0_0_0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      cyc(vecs[k].s, vecs[k].i);
      check($sformatf("vec%0d", k), 32'(dut_out()),
            32'({vecs[k].idx, vecs[k].busy, vecs[k].step, vecs[k].done}));
    end

    // Reset mid-run: 9 iterations reach index 2, then asynchronous reset between edges.
    cyc_chk("rst_start", 1, 0);
    for (int k = 0; k < 9; k++) cyc_chk("rst_iter", 0, 1);
    check("rst_pre_idx", 32'(LR_index), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 32'({LR_index, busy}), 32'({3'd0, 1'b0}));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc_chk("rst_after", 0, 1);

    // Nominal run: 28 pulses spaced 3 cycles apart.
    steps = 0; dones = 0;
    cyc_chk("nom_start", 1, 0);
    for (int p = 1; p <= LR * IPS; p++) begin
      cyc_chk("nom_pulse", 0, 1);
      steps += int'(lr_step); dones += int'(sched_done);
      for (int g = 0; g < 2; g++) begin
        cyc_chk("nom_gap", 0, 0);
        steps += int'(lr_step); dones += int'(sched_done);
      end
    end
    check("nom_steps", 32'(steps), 32'd6);
    check("nom_dones", 32'(dones), 32'd1);
    check("nom_end", 32'({LR_index, busy}), 32'({3'd0, 1'b0}));

    // Back-to-back: iter_done held high; sched_done after the 28th consecutive cycle.
    done_at = -1;
    cyc_chk("b2b_start", 1, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc_chk("b2b_iter", 0, 1);
      if (sched_done && done_at < 0) done_at = k;
      if (k < LR * IPS)
        check("b2b_idx", 32'(LR_index), 32'(k / IPS));
    end
    check("b2b_done_cycle", 32'(done_at), 32'(LR * IPS));
    check("b2b_idle", 32'({LR_index, busy}), 32'({3'd0, 1'b0}));
    cyc_chk("b2b_quiet", 0, 0);

    // Parameter corner LR_SIZE=2, ITER_PER_STEP=1.
    @(negedge clk); start_c = 1; iter_c = 0;
    @(posedge clk); #1;
    check("corner_start", 32'({idx_c, busy_c, step_c, done_c}), 32'(4'b0_1_0_0));
    @(negedge clk); start_c = 0; iter_c = 1;
    @(posedge clk); #1;
    check("corner_step", 32'({idx_c, busy_c, step_c, done_c}), 32'(4'b1_1_1_0));
    @(negedge clk); iter_c = 1;
    @(posedge clk); #1;
    check("corner_done", 32'({idx_c, busy_c, step_c, done_c}), 32'(4'b0_0_0_1));
    @(negedge clk); iter_c = 0;
    @(posedge clk); #1;
    check("corner_idle", 32'({idx_c, busy_c, step_c, done_c}), 32'(4'b0_0_0_0));

    // Randomized stimulus against the model.
    for (int k = 0; k < 1500; k++)
      cyc_chk("rand", logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
